// File: rtl/io_port_scheduler.sv
// Port-bus front end for the kcpsm6 micro: registered read mux with one-hot read pulses,
// plus a posted-write FIFO drained in strict order to RTC/VGA/KBD/SND as each becomes ready.
module io_port_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  input  logic [7:0] rd_data_rtc,
  input  logic [7:0] rd_data_vga,
  input  logic [7:0] rd_data_kbd,
  output logic [3:0] rd_sel,
  output logic [3:0] wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [3:0] wr_rdy,
  output logic       fifo_full,
  output logic       overflow,
  output logic [1:0] fsm_state
);

  localparam int               PTR_W   = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic [7:0]       fifo_addr [FIFO_DEPTH];
  logic [7:0]       fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [1:0]       state;
  logic [1:0]       state_nxt;

  logic             is_data_port;
  logic             is_status_port;
  logic             push;
  logic             drop;
  logic             pop;
  logic             clr_ovf;
  logic             empty;
  logic             head_rdy;
  logic             issue_now;
  logic [7:0]       head_addr;
  logic [7:0]       head_data;
  logic [7:0]       rd_mux;
  logic [7:0]       status_byte;
  logic [3:0]       rd_sel_nxt;
  logic [2:0]       cnt_sat;
  logic [31:0]      count_ext;

  // Targets 0x0..0x3 are queued peripherals; 0xF is the local status/control register.
  assign is_data_port   = (port_id[7:6] == 2'b00);
  assign is_status_port = (port_id[7:4] == 4'hF);

  assign fifo_full = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign fsm_state = state;

  // Full is judged on the registered count, so a same-cycle pop never makes room for a push.
  assign push    = write_strobe && is_data_port && !fifo_full;
  assign drop    = write_strobe && is_data_port && fifo_full;
  assign clr_ovf = write_strobe && is_status_port && out_port[0];
  assign pop     = (state == S_ISSUE);

  assign head_addr = fifo_addr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];
  assign head_rdy  = wr_rdy[head_addr[5:4]];

  // Write handshake: a queued entry is offered only after its target's wr_rdy bit is seen high;
  // the following cycle carries a single wr_req pulse with wr_addr/wr_data and retires the entry.
  assign issue_now = (state == S_WAIT) && head_rdy;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_WAIT;
      S_WAIT:  if (head_rdy) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (count_nxt != '0) ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    count_ext   = 32'(count);
    cnt_sat     = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];
    status_byte = {overflow, fifo_full, empty, 2'b00, cnt_sat};
  end

  always_comb begin
    rd_mux = 8'h00;
    case (port_id[7:4])
      4'h0:    rd_mux = rd_data_rtc;
      4'h1:    rd_mux = rd_data_vga;
      4'h2:    rd_mux = rd_data_kbd;
      4'hF:    rd_mux = status_byte;
      default: rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    rd_sel_nxt = 4'b0000;
    if (read_strobe) begin
      case (port_id[7:4])
        4'h0:    rd_sel_nxt = 4'b0001;
        4'h1:    rd_sel_nxt = 4'b0010;
        4'h2:    rd_sel_nxt = 4'b0100;
        default: rd_sel_nxt = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_port <= 8'h00;
      rd_sel  <= 4'b0000;
    end else begin
      in_port <= rd_mux;
      rd_sel  <= rd_sel_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= 8'h00;
        fifo_data[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= port_id;
        fifo_data[wr_ptr] <= out_port;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      wr_req  <= 4'b0000;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
    end else begin
      state  <= state_nxt;
      wr_req <= 4'b0000;
      if (issue_now) begin
        wr_req  <= 4'b0001 << head_addr[5:4];
        wr_addr <= head_addr;
        wr_data <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_io_port_scheduler.sv
// Bench for io_port_scheduler: directed scenarios plus random traffic, all checked against
// a queue-based model of the posted-write FIFO and the read mux.
module tb_io_port_scheduler;

  localparam int DEPTH = 4;

  logic       clk          = 1'b0;
  logic       reset        = 1'b0;
  logic [7:0] port_id      = 8'h70;
  logic [7:0] out_port     = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe  = 1'b0;
  logic [7:0] in_port;
  logic [7:0] rd_data_rtc  = 8'h00;
  logic [7:0] rd_data_vga  = 8'h00;
  logic [7:0] rd_data_kbd  = 8'h00;
  logic [3:0] rd_sel;
  logic [3:0] wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] wr_rdy       = 4'h0;
  logic       fifo_full;
  logic       overflow;
  logic [1:0] fsm_state;

  int checks   = 0;
  int failures = 0;

  // Reference model: queued writes as {port_id, data}, plus the sticky overflow flag.
  logic [15:0] exp_q[$];
  logic        m_ovf      = 1'b0;
  logic [7:0]  exp_in     = 8'h00;
  logic [3:0]  exp_rd_sel = 4'h0;
  logic [3:0]  prev_rdy   = 4'h0;
  logic [7:0]  last_addr  = 8'h00;
  logic [7:0]  last_data  = 8'h00;

  io_port_scheduler #(.FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .rd_data_rtc  (rd_data_rtc),
    .rd_data_vga  (rd_data_vga),
    .rd_data_kbd  (rd_data_kbd),
    .rd_sel       (rd_sel),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_rdy       (wr_rdy),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .fsm_state    (fsm_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Scoreboard: runs mid-cycle, compares every output each cycle with the model
  always @(negedge clk) begin : scoreboard
    int          sz;
    int          tgt;
    logic [15:0] e;
    logic [7:0]  st;
    if (!reset) begin
      exp_q.delete();
      m_ovf      = 1'b0;
      exp_in     = 8'h00;
      exp_rd_sel = 4'h0;
      prev_rdy   = 4'h0;
      last_addr  = 8'h00;
      last_data  = 8'h00;
    end else begin
      sz = exp_q.size();
      checks++;
      if (in_port !== exp_in) begin
        failures++;
        $display("FAIL sb_in_port: got %h expected %h at %0t", in_port, exp_in, $time);
      end
      checks++;
      if (rd_sel !== exp_rd_sel) begin
        failures++;
        $display("FAIL sb_rd_sel: got %b expected %b at %0t", rd_sel, exp_rd_sel, $time);
      end
      checks++;
      if (fifo_full !== (sz == DEPTH)) begin
        failures++;
        $display("FAIL sb_fifo_full: got %b expected %b at %0t", fifo_full, (sz == DEPTH), $time);
      end
      checks++;
      if (overflow !== m_ovf) begin
        failures++;
        $display("FAIL sb_overflow: got %b expected %b at %0t", overflow, m_ovf, $time);
      end
      if (wr_req !== 4'b0000) begin
        checks++;
        if (sz == 0) begin
          failures++;
          $display("FAIL sb_wr_req_empty: got wr_req=%b expected none (queue empty) at %0t", wr_req, $time);
        end else begin
          e   = exp_q.pop_front();
          tgt = int'(e[15:12]);
          if (wr_req !== (4'b0001 << tgt) || wr_addr !== e[15:8] || wr_data !== e[7:0] ||
              prev_rdy[tgt] !== 1'b1) begin
            failures++;
            $display("FAIL sb_wr_issue: got req=%b addr=%h data=%h prev_rdy=%b expected req=%b addr=%h data=%h rdy=1 at %0t",
                     wr_req, wr_addr, wr_data, prev_rdy, 4'b0001 << tgt, e[15:8], e[7:0], $time);
          end
          last_addr = e[15:8];
          last_data = e[7:0];
        end
      end else begin
        checks++;
        if (wr_addr !== last_addr || wr_data !== last_data) begin
          failures++;
          $display("FAIL sb_wr_hold: got addr=%h data=%h expected addr=%h data=%h at %0t",
                   wr_addr, wr_data, last_addr, last_data, $time);
        end
      end
      st = {m_ovf, (sz == DEPTH), (sz == 0), 2'b00, (sz > 7) ? 3'd7 : 3'(sz)};
      case (port_id[7:4])
        4'h0:    exp_in = rd_data_rtc;
        4'h1:    exp_in = rd_data_vga;
        4'h2:    exp_in = rd_data_kbd;
        4'hF:    exp_in = st;
        default: exp_in = 8'h00;
      endcase
      exp_rd_sel = (read_strobe && port_id[7:4] < 4'd3) ? (4'b0001 << port_id[7:4]) : 4'b0000;
      if (write_strobe) begin
        if (port_id[7:4] < 4'd4) begin
          if (sz == DEPTH) m_ovf = 1'b1;
          else exp_q.push_back({port_id, out_port});
        end else if (port_id[7:4] == 4'hF && out_port[0]) begin
          m_ovf = 1'b0;
        end
      end
      prev_rdy = wr_rdy;
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    port_id      = a;
    out_port     = d;
    write_strobe = 1'b1;
    cycle();
    write_strobe = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a);
    port_id     = a;
    read_strobe = 1'b1;
    cycle();
    read_strobe = 1'b0;
  endtask

  task automatic drain();
    wr_rdy = 4'hF;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) cycle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({in_port, rd_sel, wr_req, wr_addr, wr_data, fifo_full, overflow} !== 34'h0) begin
      failures++;
      $display("FAIL reset_outputs: got in=%h sel=%b req=%b addr=%h data=%h full=%b ovf=%b expected all 0",
               in_port, rd_sel, wr_req, wr_addr, wr_data, fifo_full, overflow);
    end
    cycle();
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_reset_mid_drain();
    wr_rdy = 4'h0;
    do_write(8'h10, 8'h11);
    do_write(8'h20, 8'h22);
    do_write(8'h30, 8'h33);
    wr_rdy = 4'hF;
    cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_port, rd_sel, wr_req, wr_addr, wr_data, fifo_full, overflow} !== 34'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got in=%h sel=%b req=%b addr=%h data=%h full=%b ovf=%b expected all 0",
               in_port, rd_sel, wr_req, wr_addr, wr_data, fifo_full, overflow);
    end
    cycle();
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (wr_req !== 4'b0000) begin
        failures++;
        $display("FAIL post_reset_wr_req: got %b expected 0000", wr_req);
      end
      cycle();
    end
    do_read(8'hF0);
    @(negedge clk);
    checks++;
    if (in_port !== 8'h20) begin
      failures++;
      $display("FAIL post_reset_status: got %h expected 20", in_port);
    end
    cycle();
  endtask

  task automatic test_single_write_latency();
    wr_rdy = 4'hF;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        port_id      = 8'h31;
        out_port     = 8'h5A;
        write_strobe = 1'b1;
      end else begin
        write_strobe = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (wr_req !== ((c == 3) ? 4'b1000 : 4'b0000)) begin
        failures++;
        $display("FAIL latency_wr_req c=%0d: got %b expected %b", c, wr_req, (c == 3) ? 4'b1000 : 4'b0000);
      end
      if (c == 3) begin
        checks++;
        if (wr_addr !== 8'h31 || wr_data !== 8'h5A) begin
          failures++;
          $display("FAIL latency_payload: got addr=%h data=%h expected addr=31 data=5a", wr_addr, wr_data);
        end
      end
      cycle();
    end
  endtask

  task automatic test_back_to_back();
    wr_rdy = 4'hF;
    for (int c = 0; c < 14; c++) begin
      if (c < 4) begin
        port_id      = 8'h10 | 8'(c);
        out_port     = 8'($urandom);
        write_strobe = 1'b1;
      end else begin
        write_strobe = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ((wr_req !== 4'b0000) != (c == 3 || c == 5 || c == 7 || c == 9)) begin
        failures++;
        $display("FAIL b2b_rate c=%0d: got wr_req=%b expected issue=%0d", c, wr_req,
                 (c == 3 || c == 5 || c == 7 || c == 9));
      end
      cycle();
    end
  endtask

  task automatic test_overflow();
    wr_rdy = 4'h0;
    for (int i = 0; i < 5; i++) do_write(8'h00, 8'($urandom));
    @(negedge clk);
    checks++;
    if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flags: got full=%b ovf=%b expected 1 1", fifo_full, overflow);
    end
    cycle();
    do_read(8'hF0);
    @(negedge clk);
    checks++;
    if (in_port !== 8'hC4) begin
      failures++;
      $display("FAIL ovf_status: got %h expected c4", in_port);
    end
    cycle();
    do_write(8'hF0, 8'h01);
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
    cycle();
    drain();
  endtask

  task automatic test_hol_blocking();
    int n;
    n      = 0;
    wr_rdy = 4'b0010;
    do_write(8'h00, 8'hA1);
    do_write(8'h10, 8'hB2);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (wr_req !== 4'b0000) begin
        failures++;
        $display("FAIL hol_blocked: got %b expected 0000", wr_req);
      end
      cycle();
    end
    wr_rdy = 4'b0011;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (wr_req !== 4'b0000) begin
        checks++;
        if ((n == 0 && (wr_req !== 4'b0001 || wr_addr !== 8'h00 || wr_data !== 8'hA1)) ||
            (n == 1 && (wr_req !== 4'b0010 || wr_addr !== 8'h10 || wr_data !== 8'hB2))) begin
          failures++;
          $display("FAIL hol_order n=%0d: got req=%b addr=%h data=%h", n, wr_req, wr_addr, wr_data);
        end
        n++;
      end
      cycle();
    end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL hol_count: got %0d issues expected 2", n);
    end
    wr_rdy = 4'h0;
    cycle();
  endtask

  task automatic test_read_path();
    logic [7:0] addrs [5];
    logic [3:0] sels  [5];
    logic [7:0] datas [5];
    rd_data_kbd = 8'hA7;
    rd_data_rtc = 8'($urandom);
    rd_data_vga = 8'($urandom);
    addrs = '{8'h20, 8'h70, 8'h05, 8'h13, 8'h3C};
    sels  = '{4'b0100, 4'b0000, 4'b0001, 4'b0010, 4'b0000};
    datas = '{8'hA7, 8'h00, rd_data_rtc, rd_data_vga, 8'h00};
    for (int i = 0; i < 5; i++) begin
      do_read(addrs[i]);
      @(negedge clk);
      checks++;
      if (in_port !== datas[i] || rd_sel !== sels[i]) begin
        failures++;
        $display("FAIL read_%h: got in=%h sel=%b expected in=%h sel=%b", addrs[i], in_port, rd_sel, datas[i], sels[i]);
      end
      cycle();
      @(negedge clk);
      checks++;
      if (rd_sel !== 4'b0000) begin
        failures++;
        $display("FAIL read_pulse_%h: got sel=%b expected 0000", addrs[i], rd_sel);
      end
      cycle();
    end
  endtask

  task automatic test_full_pop_push();
    wr_rdy = 4'h0;
    for (int i = 0; i < 4; i++) do_write(8'h00 | 8'(i), 8'($urandom));
    wr_rdy = 4'b0001;
    cycle();
    wr_rdy       = 4'h0;
    port_id      = 8'h00;
    out_port     = 8'hEE;
    write_strobe = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_req !== 4'b0001 || fifo_full !== 1'b1) begin
      failures++;
      $display("FAIL fpp_issue: got req=%b full=%b expected 0001 1", wr_req, fifo_full);
    end
    cycle();
    write_strobe = 1'b0;
    port_id      = 8'hF0;
    read_strobe  = 1'b1;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || fifo_full !== 1'b0) begin
      failures++;
      $display("FAIL fpp_flags: got ovf=%b full=%b expected 1 0", overflow, fifo_full);
    end
    cycle();
    read_strobe = 1'b0;
    @(negedge clk);
    checks++;
    if (in_port !== 8'h83) begin
      failures++;
      $display("FAIL fpp_status: got %h expected 83", in_port);
    end
    cycle();
    do_write(8'hF0, 8'h01);
    drain();
  endtask

  task automatic test_random();
    logic [3:0] hi;
    int         r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 5))
        0, 1, 2, 3: hi = 4'($urandom_range(0, 3));
        4:          hi = 4'hF;
        default:    hi = 4'($urandom_range(4, 14));
      endcase
      port_id      = {hi, 4'($urandom)};
      out_port     = 8'($urandom);
      rd_data_rtc  = 8'($urandom);
      rd_data_vga  = 8'($urandom);
      rd_data_kbd  = 8'($urandom);
      write_strobe = (r < 4);
      read_strobe  = (r >= 4 && r < 7);
      wr_rdy       = 4'($urandom);
      cycle();
    end
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_reset_mid_drain();
    test_single_write_latency();
    test_back_to_back();
    test_overflow();
    test_hol_blocking();
    test_read_path();
    test_full_pop_push();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
